// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Prefetching instruction fetch unit: sequential req/ack reads buffered in a small FIFO,
// delivering one instruction per unstalled cycle with NOP and interrupt-JAL injection.
module fetch_queue #(
    parameter int          AW      = 32,
    parameter int          IW      = 32,
    parameter int          DEPTH   = 4,
    parameter int          RST_DLY = 4,
    parameter logic [31:0] NOP_OP  = 32'h5800_0000,
    parameter logic [15:0] JAL_OP  = 16'h581f
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         set_pc,
    input  logic [AW-1:0]                pc_init,
    input  logic                         idle,
    input  logic                         jal_req,
    input  logic [15:0]                  int_srv_num,
    output logic                         mem_req,
    output logic [AW-1:0]                mem_addr,
    input  logic                         mem_ack,
    input  logic [IW-1:0]                mem_data,
    output logic                         flush_pipeline,
    output logic                         inst_vld,
    output logic [IW-1:0]                inst,
    output logic [AW-1:0]                pcn,
    output logic                         int_jal_req,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(RST_DLY + 2);

    logic [DW-1:0] dly_cnt_r;
    logic          fetch_rdy_r;
    logic          pending_r;
    logic          discard_r;
    logic [AW-1:0] req_addr_r;
    logic [AW-1:0] fetch_pc_r;
    logic [AW-1:0] deliver_pc_r;
    logic [IW-1:0] queue_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] q_count_r;
    logic          inst_vld_r;
    logic          int_jal_req_r;
    logic [IW-1:0] inst_r;
    logic [AW-1:0] pcn_r;

    logic          q_empty_s;
    logic          q_full_s;
    logic          mem_req_s;
    logic [AW-1:0] mem_addr_s;
    logic          ack_s;
    logic          push_s;
    logic          deliver_s;
    logic          pop_s;

    // Fetch/delivery qualifiers; a pending request keeps its latched address across jumps.
    always_comb begin
        q_empty_s = (q_count_r == CW'(0));
        q_full_s  = (q_count_r == CW'(DEPTH));
        mem_req_s = pending_r | (fetch_rdy_r & ~q_full_s);
        if (pending_r) begin
            mem_addr_s = req_addr_r;
        end else begin
            mem_addr_s = fetch_pc_r;
        end
        ack_s     = mem_req_s & mem_ack;
        push_s    = ack_s & ~discard_r & ~set_pc;
        deliver_s = ~stall & fetch_rdy_r & ~set_pc;
        pop_s     = deliver_s & ~jal_req & ~idle & ~q_empty_s;
    end

    // Start-up delay: fetching begins only after RST_DLY idle cycles out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dly_cnt_r   <= DW'(0);
            fetch_rdy_r <= 1'b0;
        end else begin
            if (dly_cnt_r != DW'(RST_DLY)) begin
                dly_cnt_r <= dly_cnt_r + DW'(1);
            end
            fetch_rdy_r <= (dly_cnt_r == DW'(RST_DLY));
        end
    end

    // Memory handshake tracking: outstanding request, its address, and jump discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= 1'b0;
            discard_r  <= 1'b0;
            req_addr_r <= AW'(0);
            fetch_pc_r <= AW'(0);
        end else begin
            pending_r  <= mem_req_s & ~mem_ack;
            req_addr_r <= mem_addr_s;
            if (set_pc) begin
                discard_r  <= mem_req_s & ~mem_ack;
                fetch_pc_r <= pc_init;
            end else begin
                if (ack_s) begin
                    discard_r <= 1'b0;
                end
                if (push_s) begin
                    fetch_pc_r <= fetch_pc_r + AW'(1);
                end
            end
        end
    end

    // Queue storage; stale entries are harmless because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            queue_mem_r[wr_ptr_r] <= mem_data;
        end
    end

    // Queue pointers and occupancy; a jump empties the queue.
    always_ff @(posedge clk) begin
        if (reset || set_pc) begin
            wr_ptr_r  <= PW'(0);
            rd_ptr_r  <= PW'(0);
            q_count_r <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   q_count_r <= q_count_r + CW'(1);
                2'b01:   q_count_r <= q_count_r - CW'(1);
                default: q_count_r <= q_count_r;
            endcase
        end
    end

    // Delivery to decode: JAL beats idle beats queue pop; stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_vld_r    <= 1'b0;
            int_jal_req_r <= 1'b0;
            inst_r        <= IW'(0);
            pcn_r         <= AW'(0);
            deliver_pc_r  <= AW'(0);
        end else if (set_pc) begin
            inst_vld_r    <= 1'b0;
            int_jal_req_r <= 1'b0;
            deliver_pc_r  <= pc_init;
        end else if (deliver_s) begin
            if (jal_req) begin
                inst_vld_r    <= 1'b1;
                int_jal_req_r <= 1'b1;
                inst_r        <= IW'({JAL_OP, int_srv_num});
                pcn_r         <= deliver_pc_r;
            end else if (idle) begin
                inst_vld_r    <= 1'b1;
                int_jal_req_r <= 1'b0;
                inst_r        <= IW'(NOP_OP);
                pcn_r         <= deliver_pc_r;
            end else if (!q_empty_s) begin
                inst_vld_r    <= 1'b1;
                int_jal_req_r <= 1'b0;
                inst_r        <= queue_mem_r[rd_ptr_r];
                pcn_r         <= deliver_pc_r + AW'(1);
                deliver_pc_r  <= deliver_pc_r + AW'(1);
            end else begin
                inst_vld_r    <= 1'b0;
                int_jal_req_r <= 1'b0;
            end
        end
    end

    assign mem_req        = mem_req_s;
    assign mem_addr       = mem_addr_s;
    assign flush_pipeline = set_pc;
    assign inst_vld       = inst_vld_r;
    assign inst           = inst_r;
    assign pcn            = pcn_r;
    assign int_jal_req    = int_jal_req_r;
    assign q_count        = q_count_r;

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Directed bench for fetch_queue: a behavioural memory (zero/fixed wait or hand-driven ack)
// plus a vector table for stall/jal/idle/jump and sequences for wait states, discard and reset.
module tb_fetch_queue;

    localparam int RST_DLY = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        set_pc = 1'b0;
    logic [31:0] pc_init = 32'h0;
    logic        idle = 1'b0;
    logic        jal_req = 1'b0;
    logic [15:0] int_srv_num = 16'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        flush_pipeline;
    logic        inst_vld;
    logic [31:0] inst;
    logic [31:0] pcn;
    logic        int_jal_req;
    logic [2:0]  q_count;

    int          checks = 0;
    int          errors = 0;

    // memory model controls
    int          wait_n = 0;
    int          wcnt = 0;
    bit          mode_man = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_data = 32'h0;

    fetch_queue #(.AW(32), .IW(32), .DEPTH(4), .RST_DLY(RST_DLY)) dut (
        .clk(clk), .reset(reset), .stall(stall), .set_pc(set_pc), .pc_init(pc_init),
        .idle(idle), .jal_req(jal_req), .int_srv_num(int_srv_num),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .flush_pipeline(flush_pipeline), .inst_vld(inst_vld), .inst(inst), .pcn(pcn),
        .int_jal_req(int_jal_req), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Memory returns address-as-data after wait_n low-ack cycles, or follows man_ack.
    always begin
        @(negedge clk);
        #1;
        if (mode_man) begin
            mem_ack  = man_ack;
            mem_data = man_data;
        end else if (mem_req) begin
            if (wcnt >= wait_n) begin
                mem_ack  = 1'b1;
                mem_data = mem_addr;
                wcnt     = 0;
            end else begin
                mem_ack  = 1'b0;
                wcnt     = wcnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset, check reset state, release and measure latency to the first delivered word.
    task automatic reset_measure(input bit late_ack);
        int n;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_inst_vld", 32'(inst_vld), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pcn", pcn, 32'd0);
        chk("rst_int_jal", 32'(int_jal_req), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        if (late_ack) begin
            man_ack  = 1'b1;
            man_data = 32'hBAD0_BAD0;
            mode_man = 1'b1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                if (late_ack) begin
                    chk("late_ack_q_count", 32'(q_count), 32'd0);
                    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
                end
                mode_man = 1'b0;
                man_ack  = 1'b0;
            end
        end while (!inst_vld && n < 40);
        chk("first_vld_latency", 32'(n), 32'(RST_DLY + 3));
        chk("first_inst", inst, 32'd0);
        chk("first_pcn", pcn, 32'd1);
    endtask

    typedef struct {
        bit          set_pc;
        logic [31:0] pc;
        bit          stall;
        bit          idle;
        bit          jal;
        logic [15:0] srv;
        bit          e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pcn;
        bit          e_jal;
        bit          e_req;
        logic [2:0]  e_qc;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    initial begin
        int          n;
        int          words;
        logic [31:0] exp_next;
        logic [31:0] addr_p;
        logic        prev_req;
        logic [31:0] prev_addr;

        //           set  pc     st  id  jal srv     vld inst          pcn     jal req qc
        tbl[0]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h7,        32'h8,  1'b0, 1'b1, 3'd0};
        tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h7,        32'h8,  1'b0, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h7,        32'h8,  1'b0, 1'b1, 3'd2};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h7,        32'h8,  1'b0, 1'b1, 3'd3};
        for (int i = 4; i <= 10; i++) begin
            tbl[i] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h7,     32'h8,  1'b0, 1'b0, 3'd4};
        end
        tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 16'h7, 1'b1, 32'h581f0007, 32'h20, 1'b1, 1'b0, 3'd4};
        tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h58000000, 32'h20, 1'b0, 1'b0, 3'd4};
        tbl[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h58000000, 32'h20, 1'b0, 1'b0, 3'd4};
        tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h58000000, 32'h20, 1'b0, 1'b0, 3'd4};
        tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h20,       32'h21, 1'b0, 1'b1, 3'd3};
        tbl[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h21,       32'h22, 1'b0, 1'b1, 3'd3};
        tbl[17] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h22,       32'h23, 1'b0, 1'b1, 3'd3};
        tbl[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h23,       32'h24, 1'b0, 1'b1, 3'd3};
        tbl[19] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h24,       32'h25, 1'b0, 1'b1, 3'd3};
        tbl[20] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 16'h9, 1'b1, 32'h24,       32'h25, 1'b0, 1'b0, 3'd4};
        tbl[21] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h25,       32'h26, 1'b0, 1'b1, 3'd3};

        // Reset and zero-wait streaming of addr-as-data
        reset_measure(1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk("stream_vld", 32'(inst_vld), 32'd1);
            chk("stream_inst", inst, 32'(k));
            chk("stream_pcn", pcn, 32'(k + 1));
            chk("stream_q_count", 32'(q_count), 32'd1);
        end

        // Vector table: jump to 0x20, stall fill, jal, idle, release
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_pc      = tbl[i].set_pc;
            pc_init     = tbl[i].pc;
            stall       = tbl[i].stall;
            idle        = tbl[i].idle;
            jal_req     = tbl[i].jal;
            int_srv_num = tbl[i].srv;
            #1;
            chk("flush_pipeline", 32'(flush_pipeline), 32'(tbl[i].set_pc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i), 32'(inst_vld), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
            chk($sformatf("v%0d_pcn", i), pcn, tbl[i].e_pcn);
            chk($sformatf("v%0d_jal", i), 32'(int_jal_req), 32'(tbl[i].e_jal));
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_qc", i), 32'(q_count), 32'(tbl[i].e_qc));
        end

        // Jump to all-ones: latency and pc wrap
        @(negedge clk);
        stall = 1'b0; idle = 1'b0; jal_req = 1'b0;
        set_pc = 1'b1; pc_init = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("wrap_vld_after_jump", 32'(inst_vld), 32'd0);
        chk("wrap_mem_req", 32'(mem_req), 32'd1);
        chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFFF);
        chk("wrap_q_count", 32'(q_count), 32'd0);
        @(negedge clk);
        set_pc = 1'b0;
        n = 1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!inst_vld && n < 20);
        chk("jump_latency", 32'(n), 32'd3);
        chk("wrap_inst", inst, 32'hFFFF_FFFF);
        chk("wrap_pcn", pcn, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap_next_vld", 32'(inst_vld), 32'd1);
        chk("wrap_next_inst", inst, 32'h0);
        chk("wrap_next_pcn", pcn, 32'h1);

        // Three wait states per request, jump while a request is pending
        @(negedge clk);
        set_pc = 1'b1; pc_init = 32'h40; wait_n = 3;
        prev_req = mem_req; prev_addr = mem_addr;
        exp_next = 32'h40; words = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #1;
            set_pc = 1'b0;
            if (prev_req && !mem_ack) begin
                chk("ws_req_held", 32'(mem_req), 32'd1);
                chk("ws_addr_stable", mem_addr, prev_addr);
            end
            if (q_count > 3'd1) begin
                chk("ws_q_count_max", 32'(q_count), 32'd1);
            end
            if (inst_vld) begin
                chk("ws_inst", inst, exp_next);
                chk("ws_pcn", pcn, exp_next + 32'd1);
                exp_next = exp_next + 32'd1;
                words++;
            end
            prev_req = mem_req; prev_addr = mem_addr;
        end
        chk("ws_word_count", 32'(words), 32'd10);

        // Jump with a pending request acked two cycles later: that word is dropped
        @(negedge clk);
        mode_man = 1'b1; man_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("pend_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        set_pc = 1'b1; pc_init = 32'h100;
        addr_p = mem_addr;
        @(posedge clk);
        #1;
        set_pc = 1'b0;
        chk("disc_vld_after_jump", 32'(inst_vld), 32'd0);
        chk("disc_req_kept", 32'(mem_req), 32'd1);
        chk("disc_addr_kept", mem_addr, addr_p);
        chk("disc_q_count", 32'(q_count), 32'd0);
        @(posedge clk);
        #1;
        chk("disc_addr_kept2", mem_addr, addr_p);
        @(negedge clk);
        man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("disc_dropped_q", 32'(q_count), 32'd0);
        chk("disc_dropped_vld", 32'(inst_vld), 32'd0);
        man_ack = 1'b0; mode_man = 1'b0; wait_n = 0;
        chk("disc_new_addr", mem_addr, 32'h100);
        chk("disc_new_req", 32'(mem_req), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!inst_vld && n < 20);
        chk("disc_next_inst", inst, 32'h100);
        chk("disc_next_pcn", pcn, 32'h101);

        // Reset in the middle of a transaction, then a late ack
        @(negedge clk);
        mode_man = 1'b1; man_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_pending", 32'(mem_req), 32'd1);
        reset_measure(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
